// File: rtl/axi_pkg.sv
// Constants and FSM state encodings shared by the AXI SRAM slave and its helpers.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3-style five-channel bus (4-bit IDs, 32-bit address/data) between a master and the SRAM slave.
interface axi_sram_slave_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// INCR burst address step: advance the byte address by one beat of 2^size bytes.
module axi_burst_addr_gen (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  output logic [31:0] next_addr
);

  assign next_addr = addr + (32'd1 << size);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI slave in front of a single-port 32-bit SRAM: independent read and write FSMs,
// one outstanding burst each, write beats take the SRAM port ahead of reads.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  axi_sram_slave_if.slave       bus,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  rd_state_t   rd_state, rd_next;
  wr_state_t   wr_state, wr_next;

  logic [3:0]  rd_id, wr_id;
  logic [31:0] rd_addr, rd_addr_nxt, wr_addr, wr_addr_nxt;
  logic [7:0]  rd_len, rd_beat, wr_len, wr_beat;
  logic [2:0]  rd_size, wr_size;
  logic [31:0] rd_data;
  logic        ar_hs, r_hs, aw_hs, w_hs;
  logic        unused_ok;

  axi_burst_addr_gen u_rd_addr_gen (.addr(rd_addr), .size(rd_size), .next_addr(rd_addr_nxt));
  axi_burst_addr_gen u_wr_addr_gen (.addr(wr_addr), .size(wr_size), .next_addr(wr_addr_nxt));

  // Burst type, wlast and wid carry no information: bursts end on the beat count.
  assign unused_ok = ^{bus.arburst == BURST_INCR, bus.awburst, bus.wid, bus.wlast};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_id   <= '0;
      rd_addr <= '0;
      rd_len  <= '0;
      rd_size <= '0;
      rd_beat <= '0;
      rd_data <= '0;
      wr_id   <= '0;
      wr_addr <= '0;
      wr_len  <= '0;
      wr_size <= '0;
      wr_beat <= '0;
    end else begin
      if (ar_hs) begin
        rd_id   <= bus.arid;
        rd_addr <= bus.araddr;
        rd_len  <= bus.arlen;
        rd_size <= bus.arsize;
        rd_beat <= '0;
      end
      if (rd_state == RD_WAIT) begin
        rd_data <= sram_rdata;
      end
      if (r_hs && rd_beat != rd_len) begin
        rd_beat <= rd_beat + 8'd1;
        rd_addr <= rd_addr_nxt;
      end
      if (aw_hs) begin
        wr_id   <= bus.awid;
        wr_addr <= bus.awaddr;
        wr_len  <= bus.awlen;
        wr_size <= bus.awsize;
        wr_beat <= '0;
      end
      if (w_hs && wr_beat != wr_len) begin
        wr_beat <= wr_beat + 8'd1;
        wr_addr <= wr_addr_nxt;
      end
    end
  end

  // Write side is evaluated first so a read request can see whether the port is taken.
  always_comb begin
    rd_next     = rd_state;
    wr_next     = wr_state;
    ar_hs       = 1'b0;
    r_hs        = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rdata   = rd_data;
    bus.rid     = rd_id;
    bus.rresp   = RESP_OKAY;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = wr_id;
    bus.bresp   = RESP_OKAY;
    sram_en     = 1'b0;
    sram_we     = '0;
    sram_addr   = '0;
    sram_wdata  = '0;

    case (wr_state)
      WR_IDLE: begin
        bus.awready = 1'b1;
        if (bus.awvalid) begin
          aw_hs   = 1'b1;
          wr_next = WR_DATA;
        end
      end
      WR_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          w_hs       = 1'b1;
          sram_en    = 1'b1;
          sram_we    = bus.wstrb;
          sram_addr  = wr_addr[ADDR_WIDTH+1:2];
          sram_wdata = bus.wdata;
          if (wr_beat == wr_len) wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase

    case (rd_state)
      RD_IDLE: begin
        bus.arready = 1'b1;
        if (bus.arvalid) begin
          ar_hs   = 1'b1;
          rd_next = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!w_hs) begin
          sram_en   = 1'b1;
          sram_addr = rd_addr[ADDR_WIDTH+1:2];
          rd_next   = RD_WAIT;
        end
      end
      RD_WAIT: rd_next = RD_RESP;
      RD_RESP: begin
        bus.rvalid = 1'b1;
        bus.rlast  = (rd_beat == rd_len);
        if (bus.rready) begin
          r_hs    = 1'b1;
          rd_next = (rd_beat == rd_len) ? RD_IDLE : RD_REQ;
        end
      end
      default: rd_next = RD_IDLE;
    endcase

    if (!resetn) begin
      ar_hs       = 1'b0;
      r_hs        = 1'b0;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rlast   = 1'b0;
      bus.rdata   = '0;
      bus.rid     = '0;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bid     = '0;
      sram_en     = 1'b0;
      sram_we     = '0;
      sram_addr   = '0;
      sram_wdata  = '0;
    end
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, word-address width of the attached SRAM (2^ADDR_WIDTH x 32-bit words).
REQ-002 clk  in  1  clock; all logic rising-edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 arid/araddr/arlen/arsize/arburst/arvalid  in  4/32/8/3/2/1  read address channel; arready  out  1.
REQ-005 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel; rready  in  1.
REQ-006 awid/awaddr/awlen/awsize/awburst/awvalid  in  4/32/8/3/2/1  write address channel; awready  out  1.
REQ-007 wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data channel; wready  out  1.
REQ-008 bid/bresp/bvalid  out  4/2/1  write response channel; bready  in  1.
REQ-009 sram_en  out  1, sram_we  out  4, sram_addr  out  ADDR_WIDTH, sram_wdata  out  32, sram_rdata  in  32; single-port SRAM, read data valid the cycle after sram_en & ~|sram_we.

Function
REQ-010 Read FSM states RD_IDLE, RD_REQ, RD_WAIT, RD_RESP; write FSM states WR_IDLE, WR_DATA, WR_RESP; both run concurrently, one outstanding transaction each.
REQ-011 arready = (rd_state==RD_IDLE); on arvalid&arready latch arid, araddr, arlen, arsize; beat counter := 0; go RD_REQ.
REQ-012 RD_REQ: if SRAM port granted, drive sram_en=1, sram_we=0, sram_addr=cur_addr[ADDR_WIDTH+1:2], go RD_WAIT; else stay.
REQ-013 RD_WAIT: capture sram_rdata into rdata register at clock edge; go RD_RESP.
REQ-014 RD_RESP: rvalid=1, rdata=captured word (full 32 bits regardless of arsize), rid=latched arid, rresp=2'b00, rlast=(beat==arlen); rdata/rid/rlast stable while rvalid&~rready.
REQ-015 On rvalid&rready: if beat==arlen go RD_IDLE; else beat+=1, cur_addr += (1<<arsize), go RD_REQ.
REQ-016 Uncontended read latency: ar handshake at cycle T -> first rvalid at T+3; subsequent beats every 3 cycles with rready held 1.
REQ-017 awready = (wr_state==WR_IDLE); on awvalid&awready latch awid, awaddr, awlen, awsize; beat := 0; go WR_DATA.
REQ-018 WR_DATA: wready=1; on wvalid&wready drive sram_en=1, sram_we=wstrb, sram_wdata=wdata, sram_addr=cur_addr word index in the same cycle.
REQ-019 Write beat: if beat==awlen go WR_RESP; else beat+=1, cur_addr += (1<<awsize).
REQ-020 Burst end determined solely by beat counter; wlast and wid ignored.
REQ-021 WR_RESP: bvalid=1, bid=latched awid, bresp=2'b00; hold until bready; then WR_IDLE.
REQ-022 SRAM arbitration: write beat has fixed priority; RD_REQ granted only in cycles with no write handshake; read stalls one cycle per conflict.
REQ-023 Burst type ignored; all bursts treated as INCR; address bits above ADDR_WIDTH+1 ignored (aliasing wraps modulo memory size).
REQ-024 AR and AW handshakes in the same cycle are both accepted.
REQ-025 sram_en=0 and sram_we=0 in every cycle with no granted access.

Reset
REQ-026 While resetn=0: both FSMs to IDLE, counters/latched fields 0; arready, awready, wready, rvalid, bvalid, rlast, sram_en, sram_we all 0; rdata, rid, bid 0.
REQ-027 arready and awready assert in the first cycle after resetn rises.
REQ-028 Reset mid-burst abandons the transaction: no further R or B beats issued, no further SRAM writes.

Structure
REQ-029 Shared package axi_pkg holds RESP_OKAY, BURST_INCR constants and both FSM state encodings.
REQ-030 One sub-module axi_burst_addr_gen (next address = addr + (1<<size)), instantiated once per channel.

Verification
REQ-031 Single write awaddr=0x100, awlen=0, wdata=0xDEADBEEF, wstrb=0xF -> sram_we=0xF at word 0x40; bvalid, bid=awid, bresp=0.
REQ-032 Read arid=1, araddr=0x100, arlen=0 after REQ-031 -> rvalid at T+3, rdata=0xDEADBEEF, rid=1, rlast=1.
REQ-033 Read burst araddr=0x0, arlen=3, arsize=2 with rready toggling 1/0 -> four beats from words 0..3 in order, rlast only on 4th, rdata stable while stalled.
REQ-034 Byte write awaddr=0x101, awsize=0, wstrb=0x2, wdata=0x0000AA00 over 0xDEADBEEF -> readback 0xDEADAAEF.
REQ-035 Concurrent 4-beat read and 4-beat write to disjoint words -> every write beat same-cycle, reads delayed one cycle per conflict, both complete with OKAY.
REQ-036 resetn low during beat 2 of 4-beat read -> rvalid=0 next cycle, arready=1 after release, no stray R beat.
